// File: rtl/matrix_buffer.sv
// Double-buffered ROWS x COLS matrix store: row-major streaming load into a shadow
// array with optional transpose, atomic commit to the active array, handshaked readout.
module matrix_buffer #(
  parameter int ROWS = 3,
  parameter int COLS = 3,
  parameter int W    = 3,
  parameter logic [ROWS*COLS*W-1:0] INIT =
    {3'd3, 3'd2, 3'd1, 3'd1, 3'd2, 3'd3, 3'd3, 3'd2, 3'd1}
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_start,
  input  logic                     transpose,
  input  logic                     abort,
  input  logic                     in_valid,
  input  logic [W-1:0]             in_data,
  output logic                     in_ready,
  output logic                     load_done,
  output logic [ROWS*COLS*W-1:0]   mat_out,
  input  logic                     rd_start,
  output logic                     out_valid,
  output logic [W-1:0]             out_data,
  output logic                     out_last,
  input  logic                     out_ready,
  output logic                     busy
);

  localparam int N  = ROWS * COLS;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);
  localparam logic [IW-1:0] COL_LAST = IW'(COLS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, READ} state_t;

  state_t        state;
  logic [W-1:0]  active     [N];
  logic [W-1:0]  shadow     [N];
  logic [W-1:0]  shadow_nxt [N];
  logic [IW-1:0] idx, row, col, dest, idx_inc;
  logic          xpose;
  logic          accept;

  assign in_ready = (state == LOAD);
  assign accept   = in_ready && in_valid && !abort;
  assign idx_inc  = idx + 1'b1;

  // Transposed writes land at column-major position; only reachable when square.
  assign dest = xpose ? IW'(int'(col) * COLS + int'(row)) : idx;

  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    shadow_nxt = shadow;
    if (accept) shadow_nxt[dest] = in_data;
  end

  for (genvar k = 0; k < N; k++) begin : g_flat
    assign mat_out[k*W +: W] = active[k];
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      row       <= '0;
      col       <= '0;
      xpose     <= 1'b0;
      busy      <= 1'b0;
      load_done <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      // NOTE: the arrays are reset because mat_out must show the INIT image out of reset.
      for (int k = 0; k < N; k++) begin
        active[k] <= INIT[k*W +: W];
        shadow[k] <= INIT[k*W +: W];
      end
    end else begin
      load_done <= 1'b0;
      case (state)
        IDLE: begin
          if (load_start) begin
            state <= LOAD;
            busy  <= 1'b1;
            idx   <= '0;
            row   <= '0;
            col   <= '0;
            xpose <= transpose && (ROWS == COLS);
          end else if (rd_start) begin
            state     <= READ;
            busy      <= 1'b1;
            idx       <= '0;
            out_valid <= 1'b1;
            out_data  <= active[0];
            out_last  <= (N == 1);
          end
        end
        LOAD: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (accept) begin
            shadow <= shadow_nxt;
            if (idx == IDX_LAST) begin
              active    <= shadow_nxt;
              load_done <= 1'b1;
              state     <= IDLE;
              busy      <= 1'b0;
            end else begin
              idx <= idx_inc;
              if (col == COL_LAST) begin
                col <= '0;
                row <= row + 1'b1;
              end else begin
                col <= col + 1'b1;
              end
            end
          end
        end
        READ: begin
          if (abort) begin
            state     <= IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end else if (out_ready) begin
            if (idx == IDX_LAST) begin
              state     <= IDLE;
              busy      <= 1'b0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end else begin
              idx      <= idx_inc;
              out_data <= active[idx_inc];
              out_last <= (idx_inc == IDX_LAST);
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_buffer.sv
// Directed bench for matrix_buffer: a 3x3 W=3 instance with the default INIT and a
// 2x4 W=8 instance, covering load, transpose, readout stalls, abort and async reset.
module tb_matrix_buffer;

  localparam logic [26:0] INIT_A = {3'd3, 3'd2, 3'd1, 3'd1, 3'd2, 3'd3, 3'd3, 3'd2, 3'd1};
  localparam logic [63:0] INIT_B = 64'h1716_1514_1312_1110;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        load_start_a, transpose_a, abort_a, in_valid_a, in_ready_a, load_done_a;
  logic [2:0]  in_data_a, out_data_a;
  logic [26:0] mat_out_a;
  logic        rd_start_a, out_valid_a, out_last_a, out_ready_a, busy_a;

  logic        load_start_b, transpose_b, abort_b, in_valid_b, in_ready_b, load_done_b;
  logic [7:0]  in_data_b, out_data_b;
  logic [63:0] mat_out_b;
  logic        rd_start_b, out_valid_b, out_last_b, out_ready_b, busy_b;

  matrix_buffer dut_a (
    .clk(clk), .rst(rst), .load_start(load_start_a), .transpose(transpose_a),
    .abort(abort_a), .in_valid(in_valid_a), .in_data(in_data_a), .in_ready(in_ready_a),
    .load_done(load_done_a), .mat_out(mat_out_a), .rd_start(rd_start_a),
    .out_valid(out_valid_a), .out_data(out_data_a), .out_last(out_last_a),
    .out_ready(out_ready_a), .busy(busy_a)
  );

  matrix_buffer #(.ROWS(2), .COLS(4), .W(8), .INIT(INIT_B)) dut_b (
    .clk(clk), .rst(rst), .load_start(load_start_b), .transpose(transpose_b),
    .abort(abort_b), .in_valid(in_valid_b), .in_data(in_data_b), .in_ready(in_ready_b),
    .load_done(load_done_b), .mat_out(mat_out_b), .rd_start(rd_start_b),
    .out_valid(out_valid_b), .out_data(out_data_b), .out_last(out_last_b),
    .out_ready(out_ready_b), .busy(busy_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // All tasks start and end at posedge+1, where inputs are driven and outputs sampled.
  task automatic load_a(input logic xp, input logic [26:0] din, input logic [26:0] prev);
    load_start_a = 1'b1;
    transpose_a  = xp;
    @(posedge clk); #1;
    load_start_a = 1'b0;
    transpose_a  = 1'b0;
    check("a_in_ready_rise", in_ready_a, 1);
    for (int k = 0; k < 9; k++) begin
      in_valid_a = 1'b1;
      in_data_a  = din[k*3 +: 3];
      @(posedge clk); #1;
      if (k == 4) begin
        check("a_partial_mat", mat_out_a, prev);
        check("a_partial_done", load_done_a, 0);
      end
    end
    in_valid_a = 1'b0;
    check("a_load_done_at_10", load_done_a, 1);
    check("a_busy_after_load", busy_a, 0);
  endtask

  task automatic read_a(input logic [26:0] expm, input bit toggle);
    int got;
    got = 0;
    rd_start_a = 1'b1;
    @(posedge clk); #1;
    rd_start_a = 1'b0;
    for (int cyc = 0; cyc < 40 && got < 9; cyc++) begin
      check("a_rd_valid", out_valid_a, 1);
      check("a_rd_data", out_data_a, expm[got*3 +: 3]);
      check("a_rd_last", out_last_a, got == 8);
      out_ready_a = toggle ? (cyc % 2 == 0) : 1'b1;
      @(posedge clk); #1;
      if (out_ready_a) got++;
    end
    out_ready_a = 1'b0;
    check("a_rd_count", got, 9);
    check("a_rd_valid_drop", out_valid_a, 0);
  endtask

  task automatic load_b(input logic [63:0] din);
    load_start_b = 1'b1;
    transpose_b  = 1'b1;
    @(posedge clk); #1;
    load_start_b = 1'b0;
    transpose_b  = 1'b0;
    for (int k = 0; k < 8; k++) begin
      in_valid_b = 1'b1;
      in_data_b  = din[k*8 +: 8];
      @(posedge clk); #1;
      if (k == 3) check("b_partial_mat", mat_out_b, INIT_B);
    end
    in_valid_b = 1'b0;
    check("b_load_done_at_9", load_done_b, 1);
  endtask

  task automatic read_b(input logic [63:0] expm);
    int got;
    got = 0;
    rd_start_b = 1'b1;
    @(posedge clk); #1;
    rd_start_b = 1'b0;
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      check("b_rd_valid", out_valid_b, 1);
      check("b_rd_data", out_data_b, expm[got*8 +: 8]);
      check("b_rd_last", out_last_b, got == 7);
      out_ready_b = (cyc % 2 == 0);
      @(posedge clk); #1;
      if (out_ready_b) got++;
    end
    out_ready_b = 1'b0;
    check("b_rd_count", got, 8);
    check("b_rd_valid_drop", out_valid_b, 0);
  endtask

  typedef struct packed {
    logic        xp;
    logic [26:0] din;
    logic [26:0] expm;
  } lvec_t;

  lvec_t lv [3];

  initial begin
    // Elements 1..9 truncated to 3 bits: 1,2,3,4,5,6,7,0,1.
    lv[0] = '{xp: 1'b0,
              din:  {3'd1, 3'd0, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1},
              expm: {3'd1, 3'd0, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1}};
    // Transposed 1..9 -> 1,4,7,2,5,8,3,6,9 truncated.
    lv[1] = '{xp: 1'b1,
              din:  {3'd1, 3'd0, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1},
              expm: {3'd1, 3'd6, 3'd3, 3'd0, 3'd5, 3'd2, 3'd7, 3'd4, 3'd1}};
    // Stream 0,3,6,1,4,7,2,5,0 transposed -> 0..7,0.
    lv[2] = '{xp: 1'b1,
              din:  {3'd0, 3'd5, 3'd2, 3'd7, 3'd4, 3'd1, 3'd6, 3'd3, 3'd0},
              expm: {3'd0, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}};

    {load_start_a, transpose_a, abort_a, in_valid_a, rd_start_a, out_ready_a} = '0;
    {load_start_b, transpose_b, abort_b, in_valid_b, rd_start_b, out_ready_b} = '0;
    in_data_a = '0;
    in_data_b = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mat_a", mat_out_a, INIT_A);
    check("rst_status_a", {in_ready_a, load_done_a, out_valid_a, out_last_a, busy_a}, 0);
    check("rst_data_a", out_data_a, 0);
    check("rst_mat_b", mat_out_b, INIT_B);
    check("rst_status_b", {in_ready_b, load_done_b, out_valid_b, out_last_b, busy_b}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    read_a(INIT_A, 1'b1);

    for (int i = 0; i < 3; i++) begin
      load_a(lv[i].xp, lv[i].din, (i == 0) ? INIT_A : lv[i-1].expm);
      check("a_mat_after_load", mat_out_a, lv[i].expm);
      read_a(lv[i].expm, i[0]);
    end

    // Abort a partial load: nothing commits.
    load_start_a = 1'b1;
    @(posedge clk); #1;
    load_start_a = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid_a = 1'b1;
      in_data_a  = 3'd7;
      @(posedge clk); #1;
    end
    in_valid_a = 1'b0;
    abort_a    = 1'b1;
    @(posedge clk); #1;
    abort_a = 1'b0;
    check("abort_busy", busy_a, 0);
    check("abort_in_ready", in_ready_a, 0);
    check("abort_no_done", load_done_a, 0);
    check("abort_mat", mat_out_a, lv[2].expm);
    @(posedge clk); #1;
    check("abort_no_late_done", load_done_a, 0);
    read_a(lv[2].expm, 1'b0);

    // load_start wins over rd_start.
    load_start_a = 1'b1;
    rd_start_a   = 1'b1;
    @(posedge clk); #1;
    load_start_a = 1'b0;
    rd_start_a   = 1'b0;
    check("prio_in_ready", in_ready_a, 1);
    check("prio_no_valid", out_valid_a, 0);
    @(posedge clk); #1;
    check("prio_no_valid2", out_valid_a, 0);
    abort_a = 1'b1;
    @(posedge clk); #1;
    abort_a = 1'b0;
    check("prio_abort_idle", busy_a, 0);

    // Abort mid-readout.
    rd_start_a = 1'b1;
    @(posedge clk); #1;
    rd_start_a = 1'b0;
    @(posedge clk); #1;
    check("rd_abort_hold", out_valid_a, 1);
    abort_a = 1'b1;
    @(posedge clk); #1;
    abort_a = 1'b0;
    check("rd_abort_valid", out_valid_a, 0);
    check("rd_abort_busy", busy_a, 0);

    // Commit all 7s, then reset asynchronously mid-load.
    load_a(1'b0, {9{3'd7}}, lv[2].expm);
    check("sevens_mat", mat_out_a, {9{3'd7}});
    load_start_a = 1'b1;
    @(posedge clk); #1;
    load_start_a = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid_a = 1'b1;
      in_data_a  = 3'd0;
      @(posedge clk); #1;
    end
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_mat", mat_out_a, INIT_A);
    check("async_rst_busy", busy_a, 0);
    check("async_rst_in_ready", in_ready_a, 0);
    in_valid_a = 1'b0;
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_mat", mat_out_a, INIT_A);

    // 2x4 instance: transpose must be ignored when non-square.
    check("b_rst_mat", mat_out_b, INIT_B);
    read_b(INIT_B);
    load_b(64'h1613_100D_0A07_0401);
    check("b_mat_no_transpose", mat_out_b, 64'h1613_100D_0A07_0401);
    read_b(64'h1613_100D_0A07_0401);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
